// File: rtl/audio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_pkg : shared widths, sample slice positions and channel ordering   |
// |             helper for the I2S transmitter                               |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
package audio_pkg;

  localparam int AUDIO_CH_BITS    = 16;
  localparam int AUDIO_FRAME_BITS = 32;
  localparam int AUDIO_CNT_BITS   = 5;
  localparam int AUDIO_DIV_BITS   = 8;

  localparam int AUDIO_LEFT_LSB  = 0;
  localparam int AUDIO_LEFT_MSB  = AUDIO_LEFT_LSB + AUDIO_CH_BITS - 1;
  localparam int AUDIO_RIGHT_LSB = AUDIO_CH_BITS;
  localparam int AUDIO_RIGHT_MSB = AUDIO_RIGHT_LSB + AUDIO_CH_BITS - 1;

  localparam logic [AUDIO_CNT_BITS-1:0] AUDIO_CNT_LAST = 5'd31;
  localparam logic [AUDIO_CNT_BITS-1:0] AUDIO_LR_FIRST = 5'd15;

  typedef logic [AUDIO_FRAME_BITS-1:0] audio_frame_t;

  // Left channel occupies the upper half so it leaves the shifter first.
  function automatic audio_frame_t audio_tx_word(input audio_frame_t sample);
    return {sample[AUDIO_LEFT_MSB:AUDIO_LEFT_LSB], sample[AUDIO_RIGHT_MSB:AUDIO_RIGHT_LSB]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_bclk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_bclk_gen : BCLK divider with single-cycle rise/fall strobes        |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module audio_bclk_gen
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic bclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [AUDIO_DIV_BITS-1:0] DIV_LAST = AUDIO_DIV_BITS'(CLK_DIV - 1);

  logic [AUDIO_DIV_BITS-1:0] div_q, div_d;
  logic                      bclk_q, bclk_d;
  logic                      term_cnt;

  always_comb begin
    term_cnt = enable_i && (div_q == DIV_LAST);
    div_d    = '0;
    bclk_d   = 1'b0;
    if (enable_i) begin
      div_d  = term_cnt ? '0 : div_q + 1'b1;
      bclk_d = term_cnt ? ~bclk_q : bclk_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  // Strobes mark the cycle whose closing edge moves BCLK.
  assign rise_o = term_cnt && !bclk_q;
  assign fall_o = term_cnt && bclk_q;
  assign bclk_o = bclk_q;

endmodule
`default_nettype wire

// File: rtl/audio_i2s_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | audio_i2s_tx : I2S stereo serialiser, 16-bit per channel, MSB first      |
// |   AUDIO_I2S_HOLD_LAST_EN : replay last popped sample on underrun         |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic [AUDIO_FRAME_BITS-1:0] data_i,
  input  logic                        valid_i,
  output logic                        pop_o,
  output logic                        underrun_o,
  output logic                        i2s_bclk_o,
  output logic                        i2s_lrclk_o,
  output logic                        i2s_data_o
);

  logic bclk, bclk_rise, bclk_fall;

  audio_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .bclk_o   (bclk),
    .rise_o   (bclk_rise),
    .fall_o   (bclk_fall)
  );

  logic [AUDIO_CNT_BITS-1:0] bit_cnt_q, bit_cnt_d;
  audio_frame_t              shift_q, shift_d;
  logic                      lrclk_q, lrclk_d;
  audio_frame_t              underrun_word;

`ifdef AUDIO_I2S_HOLD_LAST_EN
  audio_frame_t hold_q, hold_d;
  assign underrun_word = hold_q;
`else
  assign underrun_word = '0;
`endif

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pop_o      = 1'b0;
    underrun_o = 1'b0;
`ifdef AUDIO_I2S_HOLD_LAST_EN
    hold_d     = hold_q;
`endif
    if (!enable_i) begin
      bit_cnt_d = AUDIO_CNT_LAST;
      shift_d   = '0;
    end else if (bclk_fall) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      if (bit_cnt_q == AUDIO_CNT_LAST) begin
        if (valid_i) begin
          pop_o   = 1'b1;
          shift_d = audio_tx_word(data_i);
`ifdef AUDIO_I2S_HOLD_LAST_EN
          hold_d  = audio_tx_word(data_i);
`endif
        end else begin
          underrun_o = 1'b1;
          shift_d    = underrun_word;
        end
      end else begin
        shift_d = {shift_q[AUDIO_FRAME_BITS-2:0], 1'b0};
      end
    end
    // Word select leads each channel's MSB by one bit slot.
    lrclk_d = (bit_cnt_d >= AUDIO_LR_FIRST) && (bit_cnt_d != AUDIO_CNT_LAST);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q <= AUDIO_CNT_LAST;
      shift_q   <= '0;
      lrclk_q   <= 1'b0;
`ifdef AUDIO_I2S_HOLD_LAST_EN
      hold_q    <= '0;
`endif
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      lrclk_q   <= lrclk_d;
`ifdef AUDIO_I2S_HOLD_LAST_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign i2s_bclk_o  = bclk;
  assign i2s_lrclk_o = lrclk_q;
  assign i2s_data_o  = shift_q[AUDIO_FRAME_BITS-1];

  rise_fall_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
                                        !(bclk_rise && bclk_fall));

endmodule
`default_nettype wire
